multiplication_isoschedule_seq: RTL and testbench

//  Parametrised successor to the iso-schedule multiplication baseline.
//  - Captures one input vector (DIM_A elements) and one weight vector (DIM_C elements) per transaction.
//  - Time-multiplexes LANES input elements per cycle against all DIM_C weights.
//  - Fills a DIM_C x DIM_A product array, then presents it through a valid/ready handshake.
//  - Sits between the input/weight staging registers and the downstream accumulator/readout.

---
 rtl/multiplication_isoschedule_seq.sv | 135 +++++++++++++
 tb/tb_multiplication_isoschedule_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplication_isoschedule_seq.sv
// Time-multiplexed DIM_C x DIM_A multiplier array: LANES input elements per cycle against all weights.
// Optional MULT_ISO_ACCUM_EN adds in_acc to accumulate onto the held product array instead of overwriting.
module multiplication_isoschedule_seq #(
  parameter int unsigned DIM_A        = 8,
  parameter int unsigned DIM_C        = 4,
  parameter int unsigned INPUT_WIDTH  = 4,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned ACC_WIDTH    = 16,
  parameter int unsigned LANES        = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
`ifdef MULT_ISO_ACCUM_EN
  input  logic                               in_acc,
`endif
  input  logic [DIM_A*INPUT_WIDTH-1:0]       in_data,
  input  logic [DIM_C*WEIGHT_WIDTH-1:0]      weight,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   out_data,
  output logic                               busy
);

  localparam int unsigned STEPS  = DIM_A / LANES;
  localparam int unsigned CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned PROD_W = INPUT_WIDTH + WEIGHT_WIDTH;
  localparam int unsigned IN_W   = DIM_A * INPUT_WIDTH;
  localparam int unsigned WT_W   = DIM_C * WEIGHT_WIDTH;
  localparam int unsigned OUT_W  = DIM_C * DIM_A * ACC_WIDTH;

  if (ACC_WIDTH < PROD_W) begin : g_acc_width_check
    $error("ACC_WIDTH must be >= INPUT_WIDTH + WEIGHT_WIDTH");
  end
  if ((LANES == 0) || (LANES > DIM_A) || ((DIM_A % LANES) != 0)) begin : g_lanes_check
    $error("LANES must be in 1..DIM_A and divide DIM_A");
  end

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_HOLD} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IN_W-1:0]  in_q;
  logic [WT_W-1:0]  w_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic             acc_q;
  logic             acc_sample;
  logic             in_ready_q, out_valid_q, busy_q;

`ifdef MULT_ISO_ACCUM_EN
  assign acc_sample = in_acc;
`else
  assign acc_sample = 1'b0;
`endif

  // Product array with this step's LANES columns refreshed (or accumulated).
  always_comb begin
    int unsigned         a_idx;
    logic [PROD_W-1:0]    prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    out_d    = out_q;
    a_idx    = 0;
    prod     = '0;
    prod_ext = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      for (int unsigned c = 0; c < DIM_C; c++) begin
        a_idx    = 32'(cnt_q) * LANES + l;
        prod     = PROD_W'(in_q[a_idx*INPUT_WIDTH +: INPUT_WIDTH])
                 * PROD_W'(w_q[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
        prod_ext = ACC_WIDTH'(prod);
        out_d[(c*DIM_A + a_idx)*ACC_WIDTH +: ACC_WIDTH] =
          acc_q ? (out_q[(c*DIM_A + a_idx)*ACC_WIDTH +: ACC_WIDTH] + prod_ext) : prod_ext;
      end
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_q        <= '0;
      w_q         <= '0;
      out_q       <= '0;
      acc_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_q       <= in_data;
            w_q        <= weight;
            acc_q      <= acc_sample;
            cnt_q      <= '0;
            state_q    <= S_COMPUTE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_COMPUTE: begin
          out_q <= out_d;
          if (cnt_q == CNT_W'(STEPS - 1)) begin
            state_q     <= S_HOLD;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = out_q;

endmodule

// File: tb/tb_multiplication_isoschedule_seq.sv
// Scoreboard bench: drivers push expected arrays at accept, monitors pop on each output handshake.
module tb_multiplication_isoschedule_seq;

  localparam int OW = 4 * 8 * 16;

  typedef struct {
    logic [OW-1:0] data;
    int            exp_cyc;
  } sb_item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_valid2 = 1'b0;
  logic          in_ready, in_ready2;
  logic          in_acc_v = 1'b0;
  logic [31:0]   in_data = '0;
  logic [31:0]   weight = '0;
  logic          out_valid, out_valid2;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data, out_data2;
  logic          busy, busy2;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_err = 0;
  sb_item_t      sb1[$];
  sb_item_t      sb2[$];
  logic [OW-1:0] last_exp1 = '0, last_exp2 = '0;
  logic [OW-1:0] last_out1 = '0, last_out2 = '0;

  multiplication_isoschedule_seq #(
    .DIM_A(8), .DIM_C(4), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .ACC_WIDTH(16), .LANES(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
`ifdef MULT_ISO_ACCUM_EN
    .in_acc(in_acc_v),
`endif
    .in_data(in_data), .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  multiplication_isoschedule_seq #(
    .DIM_A(8), .DIM_C(4), .INPUT_WIDTH(4), .WEIGHT_WIDTH(8), .ACC_WIDTH(16), .LANES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
`ifdef MULT_ISO_ACCUM_EN
    .in_acc(in_acc_v),
`endif
    .in_data(in_data), .weight(weight), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ent(input logic [OW-1:0] arr, input int c, input int a);
    return arr[(c*8 + a)*16 +: 16];
  endfunction

  // Reference: unsigned 4x8 products, optionally added onto the previous array mod 2^16.
  function automatic logic [OW-1:0] model(input logic [31:0] d, input logic [31:0] w,
                                          input logic [OW-1:0] prev, input bit acc);
    logic [OW-1:0] r;
    logic [15:0]   p;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 8; a++) begin
        p = 16'(d[a*4 +: 4]) * 16'(w[c*8 +: 8]);
        r[(c*8 + a)*16 +: 16] = acc ? (prev[(c*8 + a)*16 +: 16] + p) : p;
      end
    end
    return r;
  endfunction

  task automatic issue(input int which, input logic [31:0] d, input logic [31:0] w,
                       input bit acc, input bit expect_out, output int acc_cyc);
    bit       ok;
    sb_item_t it;
    @(posedge clk); #1;
    in_data  = d;
    weight   = w;
    in_acc_v = acc;
    if (which == 1) in_valid = 1'b1; else in_valid2 = 1'b1;
    ok      = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if ((which == 1 && in_ready) || (which == 2 && in_ready2)) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout dut%0d: in_ready never seen, expected within 60 cycles", which);
    end else if (expect_out) begin
      if (which == 1) begin
        it.data = model(d, w, last_exp1, acc); last_exp1 = it.data;
`ifndef MULT_ISO_ACCUM_EN
        it.data = model(d, w, '0, 1'b0); last_exp1 = it.data;
`endif
        it.exp_cyc = acc_cyc + 9;
        sb1.push_back(it);
      end else begin
        it.data = model(d, w, last_exp2, acc); last_exp2 = it.data;
`ifndef MULT_ISO_ACCUM_EN
        it.data = model(d, w, '0, 1'b0); last_exp2 = it.data;
`endif
        it.exp_cyc = acc_cyc + 5;
        sb2.push_back(it);
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    in_acc_v  = 1'b0;
  endtask

  // Monitor for the LANES=1 instance.
  initial begin : mon1
    bit       prev_v;
    int       first_cyc;
    sb_item_t it;
    prev_v = 1'b0; first_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 1'b0;
      else begin
        if (out_valid && !prev_v) first_cyc = cyc;
        prev_v = out_valid;
        if (out_valid && out_ready) begin
          if (sb1.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dut1_unexpected_output: got out_valid, expected none");
          end else begin
            it = sb1.pop_front();
            chk("dut1_latency", OW'(first_cyc), OW'(it.exp_cyc));
            chk("dut1_array", out_data, it.data);
            last_out1 = out_data;
          end
        end
      end
    end
  end

  // Monitor for the LANES=2 instance.
  initial begin : mon2
    bit       prev_v;
    int       first_cyc;
    sb_item_t it;
    prev_v = 1'b0; first_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) prev_v = 1'b0;
      else begin
        if (out_valid2 && !prev_v) first_cyc = cyc;
        prev_v = out_valid2;
        if (out_valid2 && out_ready) begin
          if (sb2.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL dut2_unexpected_output: got out_valid, expected none");
          end else begin
            it = sb2.pop_front();
            chk("dut2_latency", OW'(first_cyc), OW'(it.exp_cyc));
            chk("dut2_array", out_data2, it.data);
            last_out2 = out_data2;
          end
        end
      end
    end
  end

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      done = (sb1.size() == 0) && (sb2.size() == 0) && in_ready && in_ready2;
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: pending dut1=%0d dut2=%0d, expected 0", sb1.size(), sb2.size());
    end
  endtask

  initial begin : main
    logic [31:0]   d1, w1, d3, w3, dmax;
    logic [OW-1:0] t1, snap, all3825;
    int            ta, tb_acc, hs_cyc, t5;
    bit            all_ok;

    for (int a = 0; a < 8; a++) d1[a*4 +: 4] = 4'(a + 1);
    w1 = {8'd1, 8'd255, 8'd0, 8'd3};
    for (int a = 0; a < 8; a++) d3[a*4 +: 4] = 4'(2*a + 1);
    w3 = {8'd7, 8'd100, 8'd2, 8'd17};
    dmax = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) all3825[i*16 +: 16] = 16'h0EF1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", OW'(in_ready), OW'(1));
    chk("rst_out_valid", OW'(out_valid), OW'(0));
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready2", OW'(in_ready2), OW'(1));

    // Ramp inputs against {3,0,255,1}
    issue(1, d1, w1, 1'b0, 1'b1, ta);
    @(negedge clk);
    chk("compute_busy", OW'(busy), OW'(1));
    chk("compute_in_ready", OW'(in_ready), OW'(0));
    drain();
    t1 = last_out1;
    chk("t1_out2_7", OW'(ent(t1, 2, 7)), OW'(2040));
    chk("t1_out0_0", OW'(ent(t1, 0, 0)), OW'(3));
    chk("t1_out3_4", OW'(ent(t1, 3, 4)), OW'(5));
    chk("t1_row1_zero", OW'(t1[8*16 +: 128]), '0);

    // Two lanes: same array, shorter latency
    issue(2, d1, w1, 1'b0, 1'b1, ta);
    drain();
    chk("lanes2_equal", last_out2, t1);

    // Maximum operands
    issue(1, dmax, dmax, 1'b0, 1'b1, ta);
    drain();
    chk("max_all_3825", last_out1, all3825);

    // Stall in HOLD with a competing request pending
    out_ready = 1'b0;
    issue(1, d3, w3, 1'b0, 1'b1, ta);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("hold_reached", OW'(out_valid), OW'(1));
    snap = out_data;
    fork
      issue(1, d1, w3, 1'b0, 1'b1, tb_acc);
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("hold_stable", out_data, snap);
          chk("hold_in_ready", OW'(in_ready), OW'(0));
          chk("hold_busy", OW'(busy), OW'(1));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
      end
    join
    chk("accept_after_hold", OW'(tb_acc), OW'(hs_cyc + 1));
    drain();

    // Reset during COMPUTE, then a fresh transaction
    issue(1, d3, w1, 1'b0, 1'b0, t5);
    for (int i = 0; i < 12 && cyc != t5 + 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", OW'(out_valid), OW'(0));
    chk("midrst_in_ready", OW'(in_ready), OW'(1));
    chk("midrst_busy", OW'(busy), OW'(0));
    chk("midrst_out_data", out_data, '0);
    @(negedge clk);
    rst = 1'b0;
    last_exp1 = '0;
    last_exp2 = '0;
    issue(1, dmax, dmax, 1'b0, 1'b1, ta);
    drain();
    chk("post_rst_3825", last_out1, all3825);

`ifdef MULT_ISO_ACCUM_EN
    // Accumulate onto the held array, then overwrite again
    issue(1, dmax, dmax, 1'b1, 1'b1, ta);
    drain();
    all_ok = 1'b1;
    for (int i = 0; i < 32; i++) if (last_out1[i*16 +: 16] !== 16'd7650) all_ok = 1'b0;
    chk("accum_7650", OW'(all_ok), OW'(1));
    issue(1, dmax, dmax, 1'b0, 1'b1, ta);
    drain();
    chk("accum_off_3825", last_out1, all3825);
`else
    all_ok = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
